// File: rtl/apb_gpio_expander.sv
// APB4 GPIO expander: GPIO_WIDTH pins with output/enable control, synchronised inputs,
// atomic set/clear/toggle and per-pin edge/level interrupts summarised onto IRQ.
module apb_gpio_expander #(
    parameter int GPIO_WIDTH  = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  FCLK,
    input  logic                  SYSRESET,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [11:0]           PADDR,
    input  logic [31:0]           PWDATA,
    input  logic [3:0]            PSTRB,
    input  logic [2:0]            PPROT,
    output logic [31:0]           PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    input  logic [GPIO_WIDTH-1:0] GPIO_IN,
    output logic [GPIO_WIDTH-1:0] GPIO_OUT,
    output logic [GPIO_WIDTH-1:0] GPIO_OEN,
    output logic [GPIO_WIDTH-1:0] IRQ_VEC,
    output logic                  IRQ
);
    localparam int W = GPIO_WIDTH;

    localparam logic [9:0] IDX_DATA_IN  = 10'd0;
    localparam logic [9:0] IDX_DATA_OUT = 10'd1;
    localparam logic [9:0] IDX_OUT_EN   = 10'd2;
    localparam logic [9:0] IDX_INT_EN   = 10'd3;
    localparam logic [9:0] IDX_INT_TYPE = 10'd4;
    localparam logic [9:0] IDX_INT_POL  = 10'd5;
    localparam logic [9:0] IDX_INT_STS  = 10'd6;
    localparam logic [9:0] IDX_OUT_SET  = 10'd7;
    localparam logic [9:0] IDX_OUT_CLR  = 10'd8;
    localparam logic [9:0] IDX_OUT_TGL  = 10'd9;

    logic [W-1:0]  sync_q [SYNC_STAGES];
    logic [W-1:0]  sync_d [SYNC_STAGES];
    logic [W-1:0]  prev_q, prev_d;
    logic [W-1:0]  data_out_q, data_out_d;
    logic [W-1:0]  out_en_q, out_en_d;
    logic [W-1:0]  int_en_q, int_en_d;
    logic [W-1:0]  int_type_q, int_type_d;
    logic [W-1:0]  int_pol_q, int_pol_d;
    logic [W-1:0]  int_sts_q, int_sts_d;
    logic [W-1:0]  irq_vec_q, irq_vec_d;
    logic          irq_q, irq_d;
    logic [31:0]   prdata_q, prdata_d;
    logic          pslverr_q, pslverr_d;

    logic [9:0]    idx;
    logic          err;
    logic          acc_wr;
    logic          setup_rd;
    logic [31:0]   strb_mask;
    logic [W-1:0]  wdat;
    logic [W-1:0]  sync_in;
    logic [W-1:0]  pol_match;
    logic [W-1:0]  edge_ev;
    logic [W-1:0]  w1c;
    logic [W-1:0]  rd_val;
    logic          unused_ok;

    assign unused_ok = ^{PPROT, PADDR[1:0], PWDATA, strb_mask};

    assign idx       = PADDR[11:2];
    // Reads of the write-only atomic registers, writes to DATA_IN and anything past 0x24 are errors.
    assign err       = PWRITE ? ((idx > IDX_OUT_TGL) || (idx == IDX_DATA_IN))
                              : (idx > IDX_INT_STS);
    assign acc_wr    = PSEL & PENABLE & PWRITE & ~err;
    assign setup_rd  = PSEL & ~PENABLE & ~PWRITE;
    assign strb_mask = {{8{PSTRB[3]}}, {8{PSTRB[2]}}, {8{PSTRB[1]}}, {8{PSTRB[0]}}};
    assign wdat      = PWDATA[W-1:0] & strb_mask[W-1:0];

    assign sync_in   = sync_q[SYNC_STAGES-1];
    assign pol_match = ~(sync_in ^ int_pol_q);
    assign edge_ev   = (sync_in ^ prev_q) & pol_match & int_en_q;
    assign w1c       = (acc_wr && idx == IDX_INT_STS) ? wdat : '0;

    always_comb begin
        sync_d[0] = GPIO_IN;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        prev_d = sync_in;
    end

    always_comb begin
        data_out_d = data_out_q;
        out_en_d   = out_en_q;
        int_en_d   = int_en_q;
        int_type_d = int_type_q;
        int_pol_d  = int_pol_q;
        if (acc_wr) begin
            unique case (idx)
                IDX_DATA_OUT: data_out_d = (data_out_q & ~strb_mask[W-1:0]) | wdat;
                IDX_OUT_EN:   out_en_d   = (out_en_q   & ~strb_mask[W-1:0]) | wdat;
                IDX_INT_EN:   int_en_d   = (int_en_q   & ~strb_mask[W-1:0]) | wdat;
                IDX_INT_TYPE: int_type_d = (int_type_q & ~strb_mask[W-1:0]) | wdat;
                IDX_INT_POL:  int_pol_d  = (int_pol_q  & ~strb_mask[W-1:0]) | wdat;
                IDX_OUT_SET:  data_out_d = data_out_q | wdat;
                IDX_OUT_CLR:  data_out_d = data_out_q & ~wdat;
                IDX_OUT_TGL:  data_out_d = data_out_q ^ wdat;
                default:      ;
            endcase
        end
    end

    // Edge pins: a new event wins over a same-cycle W1C. Level pins just track the pin.
    always_comb begin
        int_sts_d = (int_type_q & ((int_sts_q & ~w1c) | edge_ev))
                  | (~int_type_q & pol_match & int_en_q);
        irq_vec_d = int_sts_q;
        irq_d     = |int_sts_q;
    end

    always_comb begin
        rd_val = '0;
        unique case (idx)
            IDX_DATA_IN:  rd_val = sync_in;
            IDX_DATA_OUT: rd_val = data_out_q;
            IDX_OUT_EN:   rd_val = out_en_q;
            IDX_INT_EN:   rd_val = int_en_q;
            IDX_INT_TYPE: rd_val = int_type_q;
            IDX_INT_POL:  rd_val = int_pol_q;
            IDX_INT_STS:  rd_val = int_sts_q;
            default:      rd_val = '0;
        endcase
        // Captured in the setup phase, so it holds through the access phase and drops afterwards.
        prdata_d = '0;
        if (setup_rd && !err) begin
            prdata_d[W-1:0] = rd_val;
        end
        pslverr_d = PSEL & ~PENABLE & err;
    end

    always_ff @(posedge FCLK) begin
        if (SYSRESET) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev_q     <= '0;
            data_out_q <= '0;
            out_en_q   <= '0;
            int_en_q   <= '0;
            int_type_q <= '0;
            int_pol_q  <= '0;
            int_sts_q  <= '0;
            irq_vec_q  <= '0;
            irq_q      <= 1'b0;
            prdata_q   <= '0;
            pslverr_q  <= 1'b0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            prev_q     <= prev_d;
            data_out_q <= data_out_d;
            out_en_q   <= out_en_d;
            int_en_q   <= int_en_d;
            int_type_q <= int_type_d;
            int_pol_q  <= int_pol_d;
            int_sts_q  <= int_sts_d;
            irq_vec_q  <= irq_vec_d;
            irq_q      <= irq_d;
            prdata_q   <= prdata_d;
            pslverr_q  <= pslverr_d;
        end
    end

    assign PRDATA   = prdata_q;
    assign PSLVERR  = pslverr_q;
    assign PREADY   = 1'b1;
    assign GPIO_OUT = data_out_q;
    assign GPIO_OEN = out_en_q;
    assign IRQ_VEC  = irq_vec_q;
    assign IRQ      = irq_q;

endmodule

// File: tb/tb_apb_gpio_expander.sv
// Randomised APB/pin stimulus against a cycle-level register model, plus directed scenarios.
module tb_apb_gpio_expander;
    localparam int S = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        psel = 1'b0, psel8 = 1'b0, pen = 1'b0, pwrite = 1'b0;
    logic [11:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [3:0]  pstrb = '0;
    logic [2:0]  pprot = '0;
    logic [31:0] gin = '0;

    logic [31:0] prdata, gout, goen, irqv;
    logic        pready, pslverr, irq;
    logic [31:0] prdata8;
    logic [7:0]  gout8, goen8, irqv8;
    logic        pready8, pslverr8, irq8;

    apb_gpio_expander #(.GPIO_WIDTH(32), .SYNC_STAGES(S)) dut (
        .FCLK(clk), .SYSRESET(rst), .PSEL(psel), .PENABLE(pen), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
        .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr),
        .GPIO_IN(gin), .GPIO_OUT(gout), .GPIO_OEN(goen), .IRQ_VEC(irqv), .IRQ(irq));

    apb_gpio_expander #(.GPIO_WIDTH(8), .SYNC_STAGES(S)) dut8 (
        .FCLK(clk), .SYSRESET(rst), .PSEL(psel8), .PENABLE(pen), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
        .PRDATA(prdata8), .PREADY(pready8), .PSLVERR(pslverr8),
        .GPIO_IN(gin[7:0]), .GPIO_OUT(gout8), .GPIO_OEN(goen8), .IRQ_VEC(irqv8), .IRQ(irq8));

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Model of the 32-pin instance: register file plus a history of sampled pin values.
    logic [31:0] m_out, m_oen, m_ien, m_typ, m_pol, m_sts, m_irqv, m_prdata;
    logic        m_irq, m_pslverr;
    logic [31:0] hist [0:S];  // hist[0] = most recent edge sample of GPIO_IN

    function automatic logic [31:0] m_read(input logic [9:0] idx);
        case (idx)
            10'd0:   return hist[S-1];
            10'd1:   return m_out;
            10'd2:   return m_oen;
            10'd3:   return m_ien;
            10'd4:   return m_typ;
            10'd5:   return m_pol;
            10'd6:   return m_sts;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_step();
        logic [31:0] sync, prev, wm, wd;
        logic [9:0]  idx;
        logic        err, wr, ev;
        if (rst) begin
            {m_out, m_oen, m_ien, m_typ, m_pol, m_sts, m_irqv, m_prdata} = '0;
            m_irq = 1'b0; m_pslverr = 1'b0;
            for (int k = 0; k <= S; k++) hist[k] = '0;
            return;
        end
        sync = hist[S-1];
        prev = hist[S];
        idx  = paddr[11:2];
        err  = pwrite ? (idx > 10'd9 || idx == 10'd0) : (idx > 10'd6);
        wm   = {{8{pstrb[3]}}, {8{pstrb[2]}}, {8{pstrb[1]}}, {8{pstrb[0]}}};
        wd   = pwdata & wm;
        wr   = psel && pen && pwrite && !err;
        m_irqv    = m_sts;
        m_irq     = (m_sts != 0);
        m_pslverr = psel && !pen && err;
        m_prdata  = (psel && !pen && !pwrite && !err) ? m_read(idx) : 32'h0;
        for (int i = 0; i < 32; i++) begin
            if (m_typ[i]) begin
                ev = (sync[i] != prev[i]) && (sync[i] == m_pol[i]) && m_ien[i];
                m_sts[i] = (m_sts[i] && !(wr && idx == 10'd6 && wd[i])) || ev;
            end else begin
                m_sts[i] = m_ien[i] && (sync[i] == m_pol[i]);
            end
        end
        if (wr) begin
            case (idx)
                10'd1: m_out = (m_out & ~wm) | wd;
                10'd2: m_oen = (m_oen & ~wm) | wd;
                10'd3: m_ien = (m_ien & ~wm) | wd;
                10'd4: m_typ = (m_typ & ~wm) | wd;
                10'd5: m_pol = (m_pol & ~wm) | wd;
                10'd7: m_out = m_out | wd;
                10'd8: m_out = m_out & ~wd;
                10'd9: m_out = m_out ^ wd;
                default: ;
            endcase
        end
        for (int k = S; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = gin;
    endtask

    // One clock: advance the model with the current inputs, then compare outputs mid-cycle.
    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        chk("prdata", prdata, m_prdata);
        chk("pslverr", {31'b0, pslverr}, {31'b0, m_pslverr});
        chk("pready", {31'b0, pready}, 32'h1);
        chk("gpio_out", gout, m_out);
        chk("gpio_oen", goen, m_oen);
        chk("irq_vec", irqv, m_irqv);
        chk("irq", {31'b0, irq}, {31'b0, m_irq});
    endtask

    task automatic apb(input bit wr, input bit to8, input logic [11:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] rd, output logic er);
        psel = !to8; psel8 = to8; pen = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
        tick();
        rd = to8 ? prdata8 : prdata;
        er = to8 ? pslverr8 : pslverr;
        pen = 1'b1;
        tick();
        psel = 1'b0; psel8 = 1'b0; pen = 1'b0; pwrite = 1'b0;
    endtask

    task automatic wr32(input logic [11:0] a, input logic [31:0] d);
        logic [31:0] rd; logic er;
        apb(1'b1, 1'b0, a, d, 4'hF, rd, er);
    endtask

    logic [31:0] rd;
    logic        er;

    initial begin
        tick(); tick();
        rst = 1'b0;
        tick();

        // Reset state and strobed write
        for (int a = 0; a <= 6; a++) begin
            apb(1'b0, 1'b0, 12'(a * 4), 32'h0, 4'hF, rd, er);
            chk("reset_read", rd, 32'h0);
            chk("reset_err", {31'b0, er}, 32'h0);
        end
        apb(1'b1, 1'b0, 12'h004, 32'hA5A5_0F0F, 4'b0101, rd, er);
        apb(1'b0, 1'b0, 12'h004, 32'h0, 4'hF, rd, er);
        chk("strobe_write", rd, 32'h00A5_000F);

        // Atomic set / clear / toggle
        wr32(12'h004, 32'h0000_00F0);
        wr32(12'h01C, 32'h3);
        chk("out_set", gout, 32'hF3);
        wr32(12'h020, 32'h30);
        chk("out_clr", gout, 32'hC3);
        wr32(12'h024, 32'h101);
        chk("out_tgl", gout, 32'h1C2);

        // Narrow instance, unmapped read, DATA_IN write
        apb(1'b1, 1'b1, 12'h004, 32'hFFFF_FFFF, 4'hF, rd, er);
        apb(1'b0, 1'b1, 12'h004, 32'h0, 4'hF, rd, er);
        chk("width8_read", rd, 32'h0000_00FF);
        chk("width8_gpio", {24'b0, gout8}, 32'hFF);
        apb(1'b0, 1'b0, 12'h028, 32'h0, 4'hF, rd, er);
        chk("unmapped_err", {31'b0, er}, 32'h1);
        chk("unmapped_data", rd, 32'h0);
        apb(1'b0, 1'b0, 12'h01C, 32'h0, 4'hF, rd, er);
        chk("wo_read_err", {31'b0, er}, 32'h1);
        gin = 32'h1234_0000;
        repeat (4) tick();
        apb(1'b1, 1'b0, 12'h000, 32'hFFFF_FFFF, 4'hF, rd, er);
        chk("datain_wr_err", {31'b0, er}, 32'h1);
        apb(1'b0, 1'b0, 12'h000, 32'h0, 4'hF, rd, er);
        chk("datain_read", rd, 32'h1234_0000);
        gin = 32'h0;
        repeat (4) tick();

        // Rising-edge interrupt on pin 0, level-low interrupt on pin 2
        wr32(12'h010, 32'h1);
        wr32(12'h014, 32'h1);
        wr32(12'h00C, 32'h1);
        gin[0] = 1'b1;
        tick(); tick(); tick();
        chk("edge_irq_early", {31'b0, irq}, 32'h0);
        tick();
        chk("edge_irq", {31'b0, irq}, 32'h1);
        gin[0] = 1'b0;
        repeat (5) tick();
        chk("edge_irq_held", {31'b0, irq}, 32'h1);
        wr32(12'h018, 32'h1);
        tick();
        chk("w1c_irq", {31'b0, irq}, 32'h0);

        wr32(12'h00C, 32'h5);
        repeat (3) tick();
        chk("level_irqv", {31'b0, irqv[2]}, 32'h1);
        wr32(12'h018, 32'h4);
        repeat (2) tick();
        chk("level_w1c", {31'b0, irqv[2]}, 32'h1);
        gin[2] = 1'b1;
        repeat (S + 2) tick();
        chk("level_off", {31'b0, irqv[2]}, 32'h0);

        // Edge event coinciding with the W1C access edge
        gin[0] = 1'b1; repeat (4) tick();
        gin[0] = 1'b0; repeat (4) tick();
        gin[0] = 1'b1; tick();
        wr32(12'h018, 32'h1);
        apb(1'b0, 1'b0, 12'h018, 32'h0, 4'hF, rd, er);
        chk("set_beats_w1c", {31'b0, rd[0]}, 32'h1);

        // Reset during an access phase
        psel = 1'b1; pen = 1'b0; pwrite = 1'b0; paddr = 12'h018;
        tick();
        pen = 1'b1; rst = 1'b1;
        tick();
        chk("rst_prdata", prdata, 32'h0);
        chk("rst_irq", {31'b0, irq}, 32'h0);
        chk("rst_gpio", gout | goen | irqv, 32'h0);
        chk("rst_pready", {31'b0, pready}, 32'h1);
        psel = 1'b0; pen = 1'b0; rst = 1'b0;
        tick();

        // Randomised traffic
        for (int it = 0; it < 600; it++) begin
            if ($urandom_range(2) == 0) gin = gin ^ (32'h1 << $urandom_range(31));
            if ($urandom_range(7) == 0) gin = $urandom;
            if ($urandom_range(3) == 0) begin
                tick();
            end else begin
                apb(1'($urandom_range(1)), 1'b0, 12'($urandom_range(11) * 4), $urandom,
                    4'($urandom_range(15)), rd, er);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
